// File: rtl/memory_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
//   ramstate_t  : RAM port response (FREE/BUSY/ACCESS/ERROR)
//   word_t      : 32-bit data word
//   arb_state_t : arbiter state machine states
//   req_kind_t  : kind of cache request being serviced
//   BAD_WORD    : value returned on the load buses when a transfer is aborted
package memory_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RECOVER
  } arb_state_t;

  typedef enum logic [1:0] {
    K_IF,
    K_DR,
    K_DW
  } req_kind_t;

  localparam word_t BAD_WORD = 32'hBAD1BAD1;

  // Writes drive ramWEN, every other kind drives ramREN.
  function automatic logic kind_is_write(input req_kind_t kind);
    return kind == K_DW;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_if.sv
// Bus bundle between the per-CPU caches, the arbiter and the RAM port.
//   Cache side : iREN/dREN/dWEN, iaddr/daddr/dstore (requests in),
//                iwait/dwait, iload/dload (responses out)
//   RAM side   : ramaddr/ramstore/ramREN/ramWEN (out), ramload/ramstate (in)
//   Status     : err_flag (sticky abort indication)
// Modports: slave = arbiter view, master = requester/RAM-model view.
interface memory_arbiter_rr_if #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
) ();
  import memory_arbiter_rr_pkg::*;

  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0][ADDR_W-1:0] iaddr;
  logic [CPUS-1:0][ADDR_W-1:0] daddr;
  logic [CPUS-1:0][WORD_W-1:0] dstore;
  logic [CPUS-1:0]             iwait;
  logic [CPUS-1:0]             dwait;
  logic [WORD_W-1:0]           iload;
  logic [WORD_W-1:0]           dload;

  logic [ADDR_W-1:0]           ramaddr;
  logic [WORD_W-1:0]           ramstore;
  logic                        ramREN;
  logic                        ramWEN;
  logic [WORD_W-1:0]           ramload;
  ramstate_t                   ramstate;

  logic                        err_flag;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, err_flag
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, err_flag
  );

endinterface

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : one request bit per requester
//   ptr     : highest-priority requester this round
//   gnt_idx : first requesting index at or after ptr (wrapping)
//   valid   : at least one request is present
module memory_arbiter_rr_arbiter #(
  parameter int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] gnt_idx,
  output logic            valid
);

  always_comb begin
    logic [IdxW-1:0] idx;
    gnt_idx = '0;
    valid   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IdxW'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        valid   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter_rr.sv
// N-CPU memory controller: round-robin arbitration of per-CPU cache requests
// onto a single RAM port, with ERROR retry, a stall timeout and a sticky
// error flag.
//   CLK  : clock, rising edge
//   nRST : synchronous reset, active low
//   bus  : cache request/response and RAM port bundle (slave view)
// One transfer at a time: IDLE grants, XFER drives the RAM port, RECOVER
// spends one cycle with strobes low after an ERROR before reissuing.
module memory_arbiter_rr #(
  parameter int unsigned CPUS     = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned MAX_RTRY = 3
) (
  input logic                CLK,
  input logic                nRST,
  memory_arbiter_rr_if.slave bus
);
  import memory_arbiter_rr_pkg::*;

  localparam int unsigned IdxW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned CycW  = $clog2(TIMEOUT);
  localparam int unsigned RtryW = (MAX_RTRY > 0) ? $clog2(MAX_RTRY + 1) : 1;

  arb_state_t        state_q;
  req_kind_t         kind_q;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [CycW-1:0]   cyc_cnt_q;
  logic [RtryW-1:0]  rtry_cnt_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [WORD_W-1:0] ram_store_q;
  logic              ram_ren_q;
  logic              ram_wen_q;
  logic              err_flag_q;

  logic [CPUS-1:0]   any_req;
  logic              arb_valid;
  logic [IdxW-1:0]   arb_idx;
  req_kind_t         pick_kind;
  logic [ADDR_W-1:0] pick_addr;
  logic [IdxW-1:0]   ptr_next;
  logic              xfer_done;
  logic              xfer_error;
  logic              xfer_abort;

  assign any_req = bus.iREN | bus.dREN | bus.dWEN;

  memory_arbiter_rr_arbiter #(
    .N(CPUS)
  ) u_arb (
    .req     (any_req),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Within the granted CPU, writes beat data reads beat instruction fetches.
  always_comb begin
    if (bus.dWEN[arb_idx]) begin
      pick_kind = K_DW;
    end else if (bus.dREN[arb_idx]) begin
      pick_kind = K_DR;
    end else begin
      pick_kind = K_IF;
    end
    pick_addr = (pick_kind == K_IF) ? bus.iaddr[arb_idx] : bus.daddr[arb_idx];
  end

  assign ptr_next = (owner_q == IdxW'(CPUS - 1)) ? '0 : owner_q + 1'b1;

  // ACCESS always wins; otherwise an ERROR beyond the retry budget or the last
  // permitted XFER cycle ends the transfer as an abort.
  always_comb begin
    xfer_done  = (state_q == XFER) && (bus.ramstate == ACCESS);
    xfer_error = (state_q == XFER) && (bus.ramstate == ERROR);
    xfer_abort = (state_q == XFER) && !xfer_done &&
                 ((xfer_error && (rtry_cnt_q >= RtryW'(MAX_RTRY))) ||
                  (cyc_cnt_q >= CycW'(TIMEOUT - 1)));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      kind_q      <= K_IF;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cyc_cnt_q   <= '0;
      rtry_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            owner_q     <= arb_idx;
            kind_q      <= pick_kind;
            ram_addr_q  <= pick_addr;
            ram_store_q <= bus.dstore[arb_idx];
            ram_ren_q   <= !kind_is_write(pick_kind);
            ram_wen_q   <= kind_is_write(pick_kind);
            cyc_cnt_q   <= '0;
            rtry_cnt_q  <= '0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (cyc_cnt_q != '1) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end
          if (xfer_done) begin
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            rr_ptr_q  <= ptr_next;
            state_q   <= IDLE;
          end else if (xfer_abort) begin
            ram_ren_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
            err_flag_q <= 1'b1;
            state_q    <= IDLE;
          end else if (xfer_error) begin
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            if (rtry_cnt_q != '1) begin
              rtry_cnt_q <= rtry_cnt_q + 1'b1;
            end
            state_q <= RECOVER;
          end
        end
        RECOVER: begin
          // Reissue the latched transfer unchanged.
          ram_ren_q <= !kind_is_write(kind_q);
          ram_wen_q <= kind_is_write(kind_q);
          state_q   <= XFER;
        end
        default: begin
          ram_ren_q <= 1'b0;
          ram_wen_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Waits mirror requests; only the owner's matching wait drops, and only in
  // the cycle the transfer finishes (normally or by abort).
  always_comb begin
    bus.iwait = bus.iREN;
    bus.dwait = bus.dREN | bus.dWEN;
    bus.iload = bus.ramload;
    bus.dload = bus.ramload;
    if (xfer_abort) begin
      bus.iload = WORD_W'(BAD_WORD);
      bus.dload = WORD_W'(BAD_WORD);
    end
    if (xfer_done || xfer_abort) begin
      if (kind_q == K_IF) begin
        bus.iwait[owner_q] = 1'b0;
      end else begin
        bus.dwait[owner_q] = 1'b0;
      end
    end
  end

  assign bus.ramaddr  = ram_addr_q;
  assign bus.ramstore = ram_store_q;
  assign bus.ramREN   = ram_ren_q;
  assign bus.ramWEN   = ram_wen_q;
  assign bus.err_flag = err_flag_q;

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Self-checking bench for memory_arbiter_rr: directed scenarios followed by
// randomized requests and RAM responses, all checked against a transaction
// level reference model.
module tb_memory_arbiter_rr;
  import memory_arbiter_rr_pkg::*;

  localparam int unsigned CPUS     = 2;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned MAX_RTRY = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  memory_arbiter_rr_if #(.CPUS(CPUS), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  memory_arbiter_rr #(
    .CPUS     (CPUS),
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W),
    .TIMEOUT  (TIMEOUT),
    .MAX_RTRY (MAX_RTRY)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester shadow state (what each cache is currently asking for).
  bit          req_i [CPUS];
  bit          req_r [CPUS];
  bit          req_w [CPUS];
  logic [31:0] ia    [CPUS];
  logic [31:0] da    [CPUS];
  logic [31:0] ds    [CPUS];

  // Reference model: the transfer in flight, described by its attributes.
  bit          m_busy;      // a transfer has been granted and not finished
  bit          m_pause;     // this cycle is the quiet cycle after an ERROR
  bit          m_err;
  int          m_owner, m_kind;  // kind: 0 ifetch, 1 data read, 2 data write
  int          m_elapsed, m_errs, m_ptr;
  logic [31:0] m_addr, m_data;

  task automatic drive();
    for (int c = 0; c < CPUS; c++) begin
      bus.iREN[c]   = req_i[c];
      bus.dREN[c]   = req_r[c];
      bus.dWEN[c]   = req_w[c];
      bus.iaddr[c]  = ia[c];
      bus.daddr[c]  = da[c];
      bus.dstore[c] = ds[c];
    end
  endtask

  task automatic raise(input int c, input bit i, input bit r, input bit w,
                       input logic [31:0] a_i, input logic [31:0] a_d, input logic [31:0] d);
    req_i[c] = i;
    req_r[c] = r;
    req_w[c] = w;
    ia[c]    = a_i;
    da[c]    = a_d;
    ds[c]    = d;
    drive();
  endtask

  task automatic model_reset();
    m_busy = 0; m_pause = 0; m_err = 0; m_ptr = 0;
    m_owner = 0; m_kind = 0; m_elapsed = 0; m_errs = 0;
    m_addr = '0; m_data = '0;
  endtask

  // One clock cycle: apply the RAM response, check outputs mid-cycle, advance
  // the model across the rising edge, and let the served cache drop its request.
  task automatic step(input ramstate_t rs, input logic [31:0] rl);
    logic [CPUS-1:0] exp_iw, exp_dw;
    bit active, done, abort, found;
    bus.ramstate = rs;
    bus.ramload  = rl;
    #2;
    active = m_busy && !m_pause;
    done   = active && rs == ACCESS;
    abort  = active && rs != ACCESS &&
             ((rs == ERROR && m_errs >= int'(MAX_RTRY)) || m_elapsed >= int'(TIMEOUT) - 1);
    check("ramREN", bus.ramREN, active && m_kind != 2);
    check("ramWEN", bus.ramWEN, active && m_kind == 2);
    if (active) begin
      check("ramaddr", bus.ramaddr, m_addr);
      if (m_kind == 2) check("ramstore", bus.ramstore, m_data);
    end
    for (int c = 0; c < CPUS; c++) begin
      exp_iw[c] = req_i[c];
      exp_dw[c] = req_r[c] | req_w[c];
    end
    if (done || abort) begin
      if (m_kind == 0) exp_iw[m_owner] = 1'b0;
      else exp_dw[m_owner] = 1'b0;
    end
    check("iwait", bus.iwait, exp_iw);
    check("dwait", bus.dwait, exp_dw);
    if (done && m_kind == 0) check("iload", bus.iload, rl);
    if (done && m_kind == 1) check("dload", bus.dload, rl);
    if (abort) begin
      check("iload_bad", bus.iload, 32'hBAD1BAD1);
      check("dload_bad", bus.dload, 32'hBAD1BAD1);
    end
    check("err_flag", bus.err_flag, m_err);
    @(posedge clk);
    if (!m_busy) begin
      found = 0;
      for (int i = 0; i < CPUS; i++) begin
        int c;
        c = (m_ptr + i) % CPUS;
        if (!found && (req_i[c] || req_r[c] || req_w[c])) begin
          found     = 1;
          m_busy    = 1;
          m_pause   = 0;
          m_owner   = c;
          m_kind    = req_w[c] ? 2 : (req_r[c] ? 1 : 0);
          m_addr    = (m_kind == 0) ? ia[c] : da[c];
          m_data    = ds[c];
          m_elapsed = 0;
          m_errs    = 0;
        end
      end
    end else if (m_pause) begin
      m_pause = 0;
    end else begin
      m_elapsed++;
      if (done) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % CPUS;
      end else if (abort) begin
        m_busy = 0;
        m_err  = 1;
      end else if (rs == ERROR) begin
        m_pause = 1;
        m_errs++;
      end
    end
    if (done || abort) begin
      if (m_kind == 0) req_i[m_owner] = 0;
      else if (m_kind == 1) req_r[m_owner] = 0;
      else req_w[m_owner] = 0;
      drive();
    end
    #1;
  endtask

  // Grant cycle, some BUSY cycles, then a final response.
  task automatic xfer(input int n_busy, input ramstate_t fin, input logic [31:0] rl);
    step(FREE, 32'h0);
    repeat (n_busy) step(BUSY, 32'h0);
    step(fin, rl);
  endtask

  initial begin
    int r;
    for (int c = 0; c < CPUS; c++) raise(c, 0, 0, 0, '0, '0, '0);
    bus.ramstate = FREE;
    bus.ramload  = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ramREN", bus.ramREN, 1'b0);
    check("rst_ramWEN", bus.ramWEN, 1'b0);
    check("rst_ramaddr", bus.ramaddr, '0);
    check("rst_ramstore", bus.ramstore, '0);
    check("rst_err_flag", bus.err_flag, 1'b0);
    check("rst_iwait", bus.iwait, '0);
    check("rst_dwait", bus.dwait, '0);
    nrst = 1'b1;

    // CPU0 write and CPU1 ifetch together: write first, then the ifetch
    raise(0, 0, 0, 1, 32'h0, 32'h100, 32'hCAFE0001);
    raise(1, 1, 0, 0, 32'h200, 32'h0, 32'h0);
    xfer(1, ACCESS, 32'h0);
    xfer(0, ACCESS, 32'h1234ABCD);
    step(FREE, 32'h0);

    // Single ifetch with two BUSY cycles before ACCESS
    raise(0, 1, 0, 0, 32'h40, 32'h0, 32'h0);
    xfer(2, ACCESS, 32'h11112222);
    step(FREE, 32'h0);

    // One CPU with all three kinds pending
    raise(1, 1, 1, 1, 32'h400, 32'h300, 32'h5A5A5A5A);
    xfer(0, ACCESS, 32'h0);
    xfer(1, ACCESS, 32'h33334444);
    xfer(0, ACCESS, 32'h55556666);

    // Two ERRORs then ACCESS: completes without setting the flag
    raise(0, 0, 1, 0, 32'h0, 32'h500, 32'h0);
    step(FREE, 32'h0);
    step(ERROR, 32'h0);
    step(FREE, 32'h0);
    step(ERROR, 32'h0);
    step(FREE, 32'h0);
    step(ACCESS, 32'h77778888);

    // Four consecutive ERRORs: abort
    raise(1, 0, 1, 0, 32'h0, 32'h600, 32'h0);
    step(FREE, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(ERROR, 32'h0);
      if (k < 3) step(FREE, 32'h0);
    end
    step(FREE, 32'h0);

    // Stalled RAM: abort on the last permitted XFER cycle
    raise(1, 1, 0, 0, 32'h700, 32'h0, 32'h0);
    step(FREE, 32'h0);
    repeat (TIMEOUT) step(BUSY, 32'h0);
    step(FREE, 32'h0);

    // Reset in the middle of a transfer (pointer currently favours CPU1)
    raise(0, 0, 1, 0, 32'h0, 32'h800, 32'h0);
    raise(1, 1, 0, 0, 32'h900, 32'h0, 32'h0);
    step(FREE, 32'h0);
    step(BUSY, 32'h0);
    nrst = 1'b0;
    bus.ramstate = BUSY;
    @(posedge clk);
    #1;
    model_reset();
    check("mid_rst_ramREN", bus.ramREN, 1'b0);
    check("mid_rst_ramWEN", bus.ramWEN, 1'b0);
    check("mid_rst_err_flag", bus.err_flag, 1'b0);
    check("mid_rst_iwait", bus.iwait, 2'b10);
    check("mid_rst_dwait", bus.dwait, 2'b01);
    nrst = 1'b1;
    xfer(1, ACCESS, 32'h9999AAAA);
    xfer(0, ACCESS, 32'hBBBBCCCC);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!req_i[c] && !req_r[c] && !req_w[c] && $urandom_range(0, 99) < 30) begin
          r = $urandom_range(1, 7);
          raise(c, r[0], r[1], r[2], $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                $urandom);
        end
      end
      r = $urandom_range(0, 99);
      if (r < 40) step(ACCESS, $urandom);
      else if (r < 75) step(BUSY, $urandom);
      else if (r < 88) step(ERROR, $urandom);
      else step(FREE, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
